// File: rtl/sdram_host_pkg.sv
// Shared definitions for the SDRAM host request queue: default widths,
// FSM state encoding and the request-entry layout.
package sdram_host_pkg;

  localparam int ADDR_W_DEF      = 24;
  localparam int DATA_W_DEF      = 16;
  localparam int DEPTH_DEF       = 4;
  localparam int ACK_TIMEOUT_DEF = 15;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_ISSUE     = 2'd1;
  localparam state_t ST_WAIT_DONE = 2'd2;
  localparam state_t ST_WAIT_RD   = 2'd3;

  // Entry layout at default widths; the FIFO stores it flattened as
  // {write, addr, wdata} so non-default widths pack the same way.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/sdram_host_fifo.sv
// Small synchronous FIFO for host requests; DEPTH must be a power of two so
// the pointers wrap naturally.
module sdram_host_fifo #(
  parameter  int W     = 41,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_host_queue.sv
// Buffers host read/write requests and issues them one at a time to the
// SDRAM controller, pacing on its busy flag and returning read data.
//
// state     | meaning
// IDLE      | wait for a queued request and an idle controller, then pop
// ISSUE     | hold the enable until busy rises or the ack timer expires
// WAIT_DONE | controller working; wait for busy to fall
// WAIT_RD   | wait for rd_ready, then strobe the response
module sdram_host_queue
  import sdram_host_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] ctl_wr_addr,
  output logic [DATA_W-1:0] ctl_wr_data,
  output logic              ctl_wr_enable,
  output logic [ADDR_W-1:0] ctl_rd_addr,
  output logic              ctl_rd_enable,
  input  logic [DATA_W-1:0] ctl_rd_data,
  input  logic              ctl_rd_ready,
  input  logic              ctl_busy
);

  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TMR_W   = $clog2(ACK_TIMEOUT + 1);

  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_pop;

  state_t             state_q, state_d;
  logic               cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]  cmd_wdata_q, cmd_wdata_d;
  logic               wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               err_q, err_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;

  // Held low during reset so nothing is accepted while the queue is cleared.
  assign req_ready = !rst && (fifo_count != CNT_W'(DEPTH));

  sdram_host_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid && req_ready),
    .push_data ({req_write, req_addr, req_wdata}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    wr_en_d      = wr_en_q;
    rd_en_d      = rd_en_q;
    timer_d      = timer_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !ctl_busy) begin
          fifo_pop    = 1'b1;
          cmd_write_d = head[ENTRY_W-1];
          cmd_addr_d  = head[DATA_W +: ADDR_W];
          cmd_wdata_d = head[DATA_W-1:0];
          wr_en_d     = head[ENTRY_W-1];
          rd_en_d     = !head[ENTRY_W-1];
          timer_d     = TMR_W'(ACK_TIMEOUT - 1);
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ctl_busy) begin
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          state_d = cmd_write_q ? ST_WAIT_DONE : ST_WAIT_RD;
        end else if (timer_q == '0) begin
          // Never acknowledged: the command is abandoned without a response.
          err_d   = 1'b1;
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!ctl_busy) state_d = ST_IDLE;
      end
      ST_WAIT_RD: begin
        if (ctl_rd_ready) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = ctl_rd_data;
          state_d      = ctl_busy ? ST_WAIT_DONE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign ctl_wr_addr   = cmd_addr_q;
  assign ctl_rd_addr   = cmd_addr_q;
  assign ctl_wr_data   = cmd_wdata_q;
  assign ctl_wr_enable = wr_en_q;
  assign ctl_rd_enable = rd_en_q;
  assign err_timeout   = err_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;

endmodule
